// File: rtl/fp_result_collector_if.sv
// Handshake bundle between the FP add/sub pipeline, the result collector and its consumer.
// res_flags exists only when FP_COLLECT_FLAGS_EN is defined.
interface fp_result_collector_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          issue_valid;
  logic          issue_ready;
  logic          semnF;
  logic [7:0]    ExpF;
  logic [22:0]   mantisaF;
  logic          res_valid;
  logic          res_ready;
  logic [31:0]   res_data;
`ifdef FP_COLLECT_FLAGS_EN
  logic [2:0]    res_flags;
`endif
  logic [CW-1:0] count;

`ifdef FP_COLLECT_FLAGS_EN
  modport master (
    output issue_valid, semnF, ExpF, mantisaF, res_ready,
    input  issue_ready, res_valid, res_data, res_flags, count
  );
  modport slave (
    input  issue_valid, semnF, ExpF, mantisaF, res_ready,
    output issue_ready, res_valid, res_data, res_flags, count
  );
`else
  modport master (
    output issue_valid, semnF, ExpF, mantisaF, res_ready,
    input  issue_ready, res_valid, res_data, count
  );
  modport slave (
    input  issue_valid, semnF, ExpF, mantisaF, res_ready,
    output issue_ready, res_valid, res_data, count
  );
`endif
endinterface

// File: rtl/fp_result_collector.sv
// Tags issues into a free-running FP pipeline, captures results LAT edges later into a
// credit-protected FIFO. Define FP_COLLECT_FLAGS_EN to add {nan, inf, zero} flags per entry.
module fp_result_collector #(
  parameter int LAT   = 5,
  parameter int DEPTH = 8
) (
  input logic                  clk,
  input logic                  clear,
  fp_result_collector_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
`ifdef FP_COLLECT_FLAGS_EN
  localparam int EW = 35;
`else
  localparam int EW = 32;
`endif

  logic [LAT-1:0] tag_reg;
  logic [LAT-1:0] tag_next;
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW-1:0]  rd_ptr_next;
  logic [AW:0]    count_reg;
  logic [EW-1:0]  head_reg;
  logic [EW-1:0]  entry;
  logic [EW-1:0]  mem [DEPTH];
  logic [31:0]    credit_used;
  logic           ready;
  logic           accept;
  logic           push;
  logic           pop;

  // Every set bit in the tag line is a result that will need a FIFO slot.
  always_comb begin
    credit_used = 32'(count_reg);
    for (int i = 0; i < LAT; i++) begin
      credit_used = credit_used + 32'(tag_reg[i]);
    end
  end

  assign ready       = credit_used < 32'(DEPTH);
  assign accept      = bus.issue_valid && ready;
  assign push        = tag_reg[LAT-1];
  assign pop         = (count_reg != '0) && bus.res_ready;
  assign rd_ptr_next = rd_ptr_reg + AW'(pop);

  generate
    if (LAT > 1) begin : g_shift
      assign tag_next = {tag_reg[LAT-2:0], accept};
    end else begin : g_single
      assign tag_next = accept;
    end
  endgenerate

`ifdef FP_COLLECT_FLAGS_EN
  logic flag_zero;
  logic flag_inf;
  logic flag_nan;
  assign flag_zero = (bus.ExpF == 8'd0)   && (bus.mantisaF == 23'd0);
  assign flag_inf  = (bus.ExpF == 8'd255) && (bus.mantisaF == 23'd0);
  assign flag_nan  = (bus.ExpF == 8'd255) && (bus.mantisaF != 23'd0);
  assign entry     = {flag_nan, flag_inf, flag_zero, bus.semnF, bus.ExpF, bus.mantisaF};
`else
  assign entry     = {bus.semnF, bus.ExpF, bus.mantisaF};
`endif

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr_reg] <= entry;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      tag_reg    <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      tag_reg    <= tag_next;
      rd_ptr_reg <= rd_ptr_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // The RAM read is registered, so a write landing on the new head must bypass it.
      if (push && (count_reg == (AW + 1)'(pop))) begin
        head_reg <= entry;
      end else begin
        head_reg <= mem[rd_ptr_next];
      end
    end
  end

  assign bus.issue_ready = ready;
  assign bus.res_valid   = (count_reg != '0);
  assign bus.res_data    = head_reg[31:0];
  assign bus.count       = count_reg;
`ifdef FP_COLLECT_FLAGS_EN
  assign bus.res_flags   = head_reg[34:32];
`endif
endmodule

// File: tb/tb_fp_result_collector.sv
// Randomised bench for fp_result_collector: a queue-based model of the tag line and FIFO
// predicts credit, occupancy and head contents every cycle.
module tb_fp_result_collector;
  localparam int LAT   = 5;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  fp_result_collector_if #(.DEPTH(DEPTH)) bus ();

  fp_result_collector #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int edge_no = 0;
  logic [31:0] fifo_q [$];
  int          pend_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  function automatic logic [2:0] flags_of(input logic [31:0] w);
    logic zero, inf, nan;
    zero = (w[30:23] == 8'd0)   && (w[22:0] == 23'd0);
    inf  = (w[30:23] == 8'd255) && (w[22:0] == 23'd0);
    nan  = (w[30:23] == 8'd255) && (w[22:0] != 23'd0);
    return {nan, inf, zero};
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(7))
      0:       return 32'h0000_0000;
      1:       return 32'h7F80_0000;
      2:       return 32'h7FC0_0000;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // One clock cycle: drive, compare against the model at negedge, then advance the model.
  task automatic cycle(input int p_iv, input int p_rr, input logic fixed_en,
                       input logic [31:0] fixed_w, input logic do_clear);
    logic [31:0] w;
    logic        mr;
    w = fixed_en ? fixed_w : rand_word();
    bus.issue_valid = ($urandom_range(99) < p_iv);
    bus.res_ready   = ($urandom_range(99) < p_rr);
    {bus.semnF, bus.ExpF, bus.mantisaF} = w;
    clear = do_clear;
    @(negedge clk);
    mr = (fifo_q.size() + pend_q.size()) < DEPTH;
    check("issue_ready", 32'(bus.issue_ready), 32'(mr));
    check("count", 32'(bus.count), 32'(fifo_q.size()));
    check("res_valid", 32'(bus.res_valid), 32'(fifo_q.size() != 0));
    if (fifo_q.size() != 0) begin
      check("res_data", bus.res_data, fifo_q[0]);
`ifdef FP_COLLECT_FLAGS_EN
      check("res_flags", 32'(bus.res_flags), 32'(flags_of(fifo_q[0])));
`endif
    end
    @(posedge clk);
    edge_no++;
    if (do_clear) begin
      fifo_q.delete();
      pend_q.delete();
    end else begin
      if (fifo_q.size() != 0 && bus.res_ready) void'(fifo_q.pop_front());
      if (pend_q.size() != 0 && pend_q[0] == edge_no) begin
        void'(pend_q.pop_front());
        fifo_q.push_back(w);
      end
      if (bus.issue_valid && mr) pend_q.push_back(edge_no + LAT);
    end
    #1;
  endtask

  initial begin
    int p_iv;
    int p_rr;
    clear           = 1'b1;
    bus.issue_valid = 1'b0;
    bus.res_ready   = 1'b0;
    bus.semnF       = 1'b0;
    bus.ExpF        = 8'd0;
    bus.mantisaF    = 23'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_res_data", bus.res_data, 32'd0);
`ifdef FP_COLLECT_FLAGS_EN
    check("rst_res_flags", 32'(bus.res_flags), 32'd0);
`endif

    // Single issue of 3.0 with the consumer ready.
    cycle(100, 100, 1'b1, 32'h4040_0000, 1'b0);
    repeat (8) cycle(0, 100, 1'b1, 32'h4040_0000, 1'b0);

    // Streaming at full rate.
    repeat (20) cycle(100, 100, 1'b0, 32'h0, 1'b0);
    repeat (8) cycle(0, 100, 1'b0, 32'h0, 1'b0);

    // Three fill/drain rounds to exercise pointer wrap.
    for (int r = 0; r < 3; r++) begin
      repeat (14) cycle(100, 0, 1'b0, 32'h0, 1'b0);
      check("fill_count", 32'(bus.count), DEPTH);
      check("fill_issue_ready", 32'(bus.issue_ready), 32'd0);
      repeat (12) cycle(0, 100, 1'b0, 32'h0, 1'b0);
    end

    // Clear with 3 entries buffered and 2 tags in flight.
    repeat (5) cycle(100, 0, 1'b0, 32'h0, 1'b0);
    repeat (3) cycle(0, 0, 1'b0, 32'h0, 1'b0);
    cycle(0, 0, 1'b0, 32'h0, 1'b1);
    check("clr_count", 32'(bus.count), 32'd0);
    check("clr_res_valid", 32'(bus.res_valid), 32'd0);
    repeat (8) cycle(0, 100, 1'b0, 32'h0, 1'b0);

    // Random traffic with occasional clears.
    for (int b = 0; b < 60; b++) begin
      p_iv = $urandom_range(100);
      p_rr = $urandom_range(100);
      for (int c = 0; c < 50; c++) begin
        cycle(p_iv, p_rr, 1'b0, 32'h0, ($urandom_range(199) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
